// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 register file, exception commit and Count/Compare timer (option: CP0_TIMER_INT_EN)
package cp0_pkg;
    typedef struct packed {
        logic [31:0] badvaddr;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
    } cp0_t;
endpackage

module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        c_valid,
    input  logic [31:0] c_pc,
    input  logic        c_bd,
    input  logic        c_exc,
    input  logic [4:0]  c_exccode,
    input  logic        c_badva_vld,
    input  logic [31:0] c_badva,
    input  logic        c_eret,
    input  logic        c_wen,
    input  logic [4:0]  c_waddr,
    input  logic [31:0] c_wdata,
    input  logic [5:0]  ext_int,
    output cp0_t        cp0_nxt,
    output logic        flush,
    output logic [31:0] redirect_pc
);

    // Status bits software may change: IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] badvaddr_q, count_q, compare_q, status_q, epc_q;
    logic [31:0] badvaddr_d, count_d, compare_d, status_d, epc_d;
    logic        bd_q, bd_d, ti_q, ti_d, toggle_q, toggle_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        active, tick, int_req, take_exc, do_eret, do_wen;
    logic [7:0]  ip_cur;

    // Commit decision and next-state computation for every CP0 field
    always_comb begin
        // A commit held while reset is asserted must not leak onto the outputs
        active   = c_valid & resetn;
        tick     = toggle_q;
        ip_cur   = {ext_int[5] | ti_q, ext_int[4:0], ip_sw_q};
        int_req  = status_q[0] & ~status_q[1] & (|(ip_cur & status_q[15:8]));
        take_exc = active & (int_req | c_exc);
        do_eret  = active & ~take_exc & c_eret;
        do_wen   = active & ~take_exc & ~c_eret & c_wen;

        badvaddr_d = badvaddr_q;
        count_d    = count_q + {31'd0, tick};
        compare_d  = compare_q;
        status_d   = status_q;
        epc_d      = epc_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        toggle_d   = ~toggle_q;
`ifdef CP0_TIMER_INT_EN
        ti_d       = ti_q | (tick & (count_q == compare_q));
`else
        ti_d       = 1'b0;
`endif

        if (take_exc) begin
            // Nested exceptions keep the original return point
            if (!status_q[1]) begin
                epc_d = c_bd ? (c_pc - 32'd4) : c_pc;
                bd_d  = c_bd;
            end
            status_d[1] = 1'b1;
            exccode_d   = int_req ? 5'd0 : c_exccode;
            if (c_badva_vld) begin
                badvaddr_d = c_badva;
            end
        end else if (do_eret) begin
            status_d[1] = 1'b0;
        end else if (do_wen) begin
            case (c_waddr)
                5'd9: begin
                    count_d  = c_wdata;
                    toggle_d = 1'b0;
                end
                5'd11: begin
                    compare_d = c_wdata;
`ifdef CP0_TIMER_INT_EN
                    ti_d      = 1'b0;
`endif
                end
                5'd12:   status_d = (status_q & ~STATUS_WMASK) | (c_wdata & STATUS_WMASK);
                5'd13:   ip_sw_d  = c_wdata[9:8];
                5'd14:   epc_d    = c_wdata;
                default: ;
            endcase
        end
    end

    // Next-state view for decode, pipeline flush and redirect target
    always_comb begin
        cp0_nxt.badvaddr = badvaddr_d;
        cp0_nxt.count    = count_d;
        cp0_nxt.compare  = compare_d;
        cp0_nxt.status   = status_d;
        cp0_nxt.cause    = {bd_d, ti_d, 14'd0, ext_int[5] | ti_d, ext_int[4:0],
                            ip_sw_d, 1'b0, exccode_d, 2'b00};
        cp0_nxt.epc      = epc_d;
        flush            = take_exc | do_eret;
        redirect_pc      = take_exc ? EXC_VECTOR : (do_eret ? epc_q : 32'd0);
    end

    // CP0 state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            status_q   <= STATUS_RST;
            epc_q      <= 32'd0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            toggle_q   <= 1'b0;
            ip_sw_q    <= 2'b00;
            exccode_q  <= 5'd0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            toggle_q   <= toggle_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - scoreboard bench for cp0_unit
module tb_cp0_unit;
    import cp0_pkg::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [31:0] BVA = 32'h1234_5678;

    typedef struct {
        logic        flush;
        logic [31:0] redirect;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] badvaddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        c_valid, c_bd, c_exc, c_badva_vld, c_eret, c_wen;
    logic [31:0] c_pc, c_badva, c_wdata;
    logic [4:0]  c_exccode, c_waddr;
    logic [5:0]  ext_int;
    cp0_t        cp0_nxt;
    logic        flush;
    logic [31:0] redirect_pc;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    cp0_unit dut (
        .clk(clk), .resetn(resetn), .c_valid(c_valid), .c_pc(c_pc), .c_bd(c_bd),
        .c_exc(c_exc), .c_exccode(c_exccode), .c_badva_vld(c_badva_vld),
        .c_badva(c_badva), .c_eret(c_eret), .c_wen(c_wen), .c_waddr(c_waddr),
        .c_wdata(c_wdata), .ext_int(ext_int), .cp0_nxt(cp0_nxt), .flush(flush),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic [31:0] r, input logic [31:0] s,
                                input logic [31:0] c, input logic [31:0] ep, input logic [31:0] bv);
        exp_t e;
        e.flush = f; e.redirect = r; e.status = s; e.cause = c; e.epc = ep; e.badvaddr = bv;
        return e;
    endfunction

    task automatic idle_inputs();
        c_valid = 0; c_bd = 0; c_exc = 0; c_badva_vld = 0; c_eret = 0; c_wen = 0;
        c_pc = 0; c_badva = 0; c_wdata = 0; c_exccode = 0; c_waddr = 0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic bd, input logic exc,
                          input logic [4:0] code, input logic bvld, input logic [31:0] bva,
                          input logic eret, input logic wen, input logic [4:0] wa,
                          input logic [31:0] wd, input exp_t e);
        c_valid = 1; c_pc = pc; c_bd = bd; c_exc = exc; c_exccode = code;
        c_badva_vld = bvld; c_badva = bva; c_eret = eret; c_wen = wen;
        c_waddr = wa; c_wdata = wd;
        sb.push_back(e);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
        commit(32'h8000_1000, 0, 0, 0, 0, 0, 0, 1, wa, wd, e);
    endtask

    task automatic plain(input logic [31:0] pc, input exp_t e);
        commit(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic eret(input exp_t e);
        commit(32'h8000_2000, 0, 0, 0, 0, 0, 1, 0, 0, 0, e);
    endtask

    // Monitor: every live commit cycle is compared against the oldest expectation
    always @(negedge clk) begin
        if (resetn === 1'b1 && c_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_empty: commit at %0t with no expectation", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("flush",    {31'd0, flush},    {31'd0, e.flush});
                chk("redirect", redirect_pc,       e.redirect);
                chk("status",   cp0_nxt.status,    e.status);
                chk("cause",    cp0_nxt.cause,     e.cause);
                chk("epc",      cp0_nxt.epc,       e.epc);
                chk("badvaddr", cp0_nxt.badvaddr,  e.badvaddr);
            end
        end
    end

    logic [31:0] x_st, x_ca, x_ep, x_rd, x_ti;
    logic        x_fl;
    bit          seen;

    initial begin
        resetn = 0; ext_int = 0;
        idle_inputs();
        #12;
        chk("rst_status", cp0_nxt.status, 32'h0040_0000);
        chk("rst_cause",  cp0_nxt.cause,  32'h0);
        chk("rst_count",  cp0_nxt.count,  32'h0);
        chk("rst_flush",  {31'd0, flush}, 32'h0);
        @(posedge clk); #1;
        resetn = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("count_10clk", cp0_nxt.count, 32'd5);

        // Park Compare away from Count so the timer stays quiet
        mtc0(5'd11, 32'hFFFF_0000, mk(0, 0, 32'h0040_0000, 32'h0, 32'h0, 32'h0));

        // Exception in a delay slot
        commit(32'h8000_0010, 1, 1, 5'd10, 0, 0, 0, 0, 0, 0,
               mk(1, VEC, 32'h0040_0002, 32'h8000_0028, 32'h8000_000C, 32'h0));
        // Nested exception: EPC/BD held, ExcCode and BadVAddr updated
        commit(32'h8000_0100, 0, 1, 5'd4, 1, BVA, 0, 0, 0, 0,
               mk(1, VEC, 32'h0040_0002, 32'h8000_0010, 32'h8000_000C, BVA));
        eret(mk(1, 32'h8000_000C, 32'h0040_0000, 32'h8000_0010, 32'h8000_000C, BVA));
        // BadVAddr is read-only
        mtc0(5'd8, 32'hDEAD_BEEF, mk(0, 0, 32'h0040_0000, 32'h8000_0010, 32'h8000_000C, BVA));
        // Exception drops the mtc0 carried by the same instruction
        commit(32'h8000_0200, 0, 1, 5'd8, 0, 0, 0, 1, 5'd14, 32'hAAAA_AAAA,
               mk(1, VEC, 32'h0040_0002, 32'h0000_0020, 32'h8000_0200, BVA));
        eret(mk(1, 32'h8000_0200, 32'h0040_0000, 32'h0000_0020, 32'h8000_0200, BVA));

        // Timer interrupt
        mtc0(5'd12, 32'h0000_FF01, mk(0, 0, 32'h0040_FF01, 32'h0000_0020, 32'h8000_0200, BVA));
        mtc0(5'd11, 32'd20,        mk(0, 0, 32'h0040_FF01, 32'h0000_0020, 32'h8000_0200, BVA));
        mtc0(5'd9,  32'd18,        mk(0, 0, 32'h0040_FF01, 32'h0000_0020, 32'h8000_0200, BVA));
        chk("count_load", cp0_nxt.count, 32'd18);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cp0_nxt.cause[30]) seen = 1;
        end
`ifdef CP0_TIMER_INT_EN
        x_ti = 32'd1;
        x_fl = 1; x_rd = VEC; x_st = 32'h0040_FF03; x_ca = 32'h4000_8000; x_ep = 32'h8000_0300;
`else
        x_ti = 32'd0;
        x_fl = 0; x_rd = 0;   x_st = 32'h0040_FF01; x_ca = 32'h0000_0020; x_ep = 32'h8000_0200;
`endif
        chk("ti_seen", {31'd0, seen}, x_ti);
        @(posedge clk); #1;
        plain(32'h8000_0300, mk(x_fl, x_rd, x_st, x_ca, x_ep, BVA));
`ifdef CP0_TIMER_INT_EN
        x_ca = 32'h0;
`endif
        mtc0(5'd11, 32'hFFFF_0000, mk(0, 0, x_st, x_ca, x_ep, BVA));
        eret(mk(1, x_ep, 32'h0040_FF01, x_ca, x_ep, BVA));

        // Hardware interrupt waits for a valid commit
        ext_int = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_noflush", {31'd0, flush}, 32'h0);
        end
        @(posedge clk); #1;
        plain(32'h8000_0400, mk(1, VEC, 32'h0040_FF03, 32'h0000_0400, 32'h8000_0400, BVA));
        ext_int = 6'b000000;

        // Software IP bits: only [9:8] writable; interrupt fires once EXL clears
        mtc0(5'd13, 32'hFFFF_FFFF, mk(0, 0, 32'h0040_FF03, 32'h0000_0300, 32'h8000_0400, BVA));
        mtc0(5'd13, 32'h0,         mk(0, 0, 32'h0040_FF03, 32'h0000_0000, 32'h8000_0400, BVA));
        eret(mk(1, 32'h8000_0400, 32'h0040_FF01, 32'h0, 32'h8000_0400, BVA));
        mtc0(5'd13, 32'h0000_0100, mk(0, 0, 32'h0040_FF01, 32'h0000_0100, 32'h8000_0400, BVA));
        plain(32'h8000_0500, mk(1, VEC, 32'h0040_FF03, 32'h0000_0100, 32'h8000_0500, BVA));

        // Reset in the middle of an exception commit
        c_valid = 1; c_exc = 1; c_exccode = 5'd12; c_pc = 32'h8000_0600;
        #1 resetn = 0;
        #1;
        chk("rst_mid_flush",  {31'd0, flush}, 32'h0);
        chk("rst_mid_redir",  redirect_pc,    32'h0);
        chk("rst_mid_status", cp0_nxt.status, 32'h0040_0000);
        chk("rst_mid_epc",    cp0_nxt.epc,    32'h0);
        chk("rst_mid_cause",  cp0_nxt.cause,  32'h0);
        @(posedge clk); #1;
        idle_inputs();
        resetn = 1;
        #1;
        chk("post_rst_epc", cp0_nxt.epc, 32'h0);
        chk("post_rst_bva", cp0_nxt.badvaddr, 32'h0);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
